pcie_lcrc_rx_check: RTL and testbench
=====================================

# pcie_lcrc_rx_check

Receive-side PCIe Data Link Layer LCRC checker for byte-wide AXI-Stream TLP traffic. Accepts a TLP followed by its 4-byte LCRC, recomputes the LCRC over the payload bytes, strips the LCRC and forwards the payload. The last forwarded beat is flagged when the received LCRC does not match. It sits between the link deframer and the TLP receive path, and is the counterpart of the transmit-side LCRC generator.

## Interface
- LCRC_SEED, 32'hFFFF_FFFF: CRC register value at reset and at every packet start.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  input byte; byte bit 0 is the first bit on the wire.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  input byte accepted when tvalid && tready.
- s_axis_tlast  in  1  marks the last LCRC byte of the packet.
- m_axis_tdata  out  8  forwarded payload byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last payload byte of the packet.
- m_axis_tuser  out  1  LCRC mismatch; meaningful only on the tlast beat, 0 on all other beats.
- crc_err  out  1  one-cycle pulse: packet failed the check.
- crc_ok  out  1  one-cycle pulse: packet passed the check.
- runt_err  out  1  one-cycle pulse: packet of 4 or fewer bytes was dropped.

## Operation
- CRC: polynomial 0x04C11DB7, one byte per step, data bit 0 shifted first. The running register R is updated once for each byte that leaves the delay line, so it covers payload bytes only.
- Delay line: 4-byte shift register sr[0..3] (sr[3] is oldest) with a fill count of 0..4. A byte is known to be payload only once 4 younger bytes have arrived.
- Accepted beat with fill < 4: shift the byte in and increment fill; no output is produced.
- Accepted beat with fill == 4 and no tlast: sr[3] goes to the output register with m_axis_tlast=0 and m_axis_tuser=0; R <= crc8(R, sr[3]); the new byte shifts in.
- Accepted beat with fill == 4 and tlast:
  - sr[3] goes to the output register with m_axis_tlast=1.
  - Rf = crc8(R, sr[3]).
  - The received LCRC bytes, in wire order, are {sr[2], sr[1], sr[0], incoming byte}.
  - The expected wire byte k (k=0..3) is bitrev8(~Rf[31-8k -: 8]).
  - m_axis_tuser = 1 if any byte differs. crc_err or crc_ok pulses accordingly.
  - fill <= 0 and R <= LCRC_SEED.
- Accepted tlast with fill < 4 (packet of 1–4 bytes): nothing is forwarded, runt_err pulses, fill <= 0, R <= LCRC_SEED.
- Backpressure: s_axis_tready = rst_n released && (fill < 4 || !m_axis_tvalid || m_axis_tready).
- The output register holds tdata/tlast/tuser stable while tvalid && !tready.
- Back-to-back packets: the first byte of the next packet may be accepted in the cycle after tlast. No idle cycle is required.

## Timing
- Reset values: s_axis_tready=0 while rst_n=0; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, crc_err=0, crc_ok=0, runt_err=0, fill=0, R=LCRC_SEED.
- Payload byte n appears on m_axis the cycle after input byte n+4 is accepted.
- The final payload beat, with tlast and tuser, appears the cycle after the input tlast beat is accepted.
- crc_err, crc_ok and runt_err are asserted in that same cycle, for one cycle only.
- Full throughput is 1 byte/cycle when m_axis_tready is held at 1.
- Simultaneous output pop and input push in one cycle is allowed; the register reloads with no bubble.
- If rst_n asserts mid-packet, the partial packet is discarded. The next byte after reset release starts a new packet.
- The s_axis_tready combinational path depends on m_axis_tready only. No combinational path exists from s_axis_tvalid to any output.

## Test plan
- Good packet: 12-byte TLP 0x00..0x0B plus the correct LCRC from the bench model, m_tready=1 → exactly 12 output bytes 0x00..0x0B, tlast on 0x0B, tuser=0, one crc_ok pulse, first output 5 cycles after first input.
- Corrupt LCRC: same packet with the last LCRC byte XOR 0x01 → same 12 bytes, tuser=1 on last beat, one crc_err pulse. Repeat with payload byte 5 XOR 0x80 → same error response.
- Runts: packets of 1, 4 and 5 bytes (the 5-byte packet has 1 payload byte and a correct LCRC) → the 1- and 4-byte packets produce no output and one runt_err each; the 5-byte packet produces one byte with tlast=1, tuser=0.
- Backpressure: random m_tready (50%) and random s_tvalid over 200 packets of 5–64 bytes → output matches the model byte-for-byte; held data is stable while stalled; no loss or duplication.
- Back-to-back: 3 packets with no gap, the middle one corrupted → tuser pattern 0,1,0; pulses crc_ok, crc_err, crc_ok.
- Reset mid-packet: assert rst_n=0 after 7 of 20 bytes, then send a fresh good packet → no stale output, and the fresh packet passes with crc_ok.

Source files
------------

// File: rtl/pcie_lcrc_rx_check.sv
// Receive-side PCIe LCRC checker: delays the byte stream by four bytes to strip the trailing LCRC,
// recomputes the LCRC over the payload and flags the final forwarded beat on a mismatch.
module pcie_lcrc_rx_check #(
  parameter logic [31:0] LCRC_SEED = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       crc_err,
  output logic       crc_ok,
  output logic       runt_err
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  // One byte of CRC-32, data bit 0 enters first, register shifts toward bit 31.
  function automatic logic [31:0] crc8(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = r;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = b[7-i];
    return o;
  endfunction

  logic [7:0]  sr_q [4];
  logic [7:0]  sr_d [4];
  logic [2:0]  fill_q, fill_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        out_user_q, out_user_d;
  logic        err_q, err_d;
  logic        ok_q, ok_d;
  logic        runt_q, runt_d;

  logic        full;
  logic        accept;
  logic [31:0] crc_final;
  logic [7:0]  rx_byte [4];
  logic [7:0]  exp_byte [4];
  logic [3:0]  byte_bad;
  logic        lcrc_bad;

  assign full          = (fill_q == 3'd4);
  assign s_axis_tready = rst_n && (!full || !out_valid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // CRC including the oldest held byte, which is the final payload byte when tlast arrives.
  assign crc_final = crc8(crc_q, sr_q[3]);

  // Received LCRC in wire order: three held bytes, then the incoming one.
  assign rx_byte[0] = sr_q[2];
  assign rx_byte[1] = sr_q[1];
  assign rx_byte[2] = sr_q[0];
  assign rx_byte[3] = s_axis_tdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
      assign exp_byte[gi] = bitrev8(~crc_final[31-8*gi -: 8]);
      assign byte_bad[gi] = (rx_byte[gi] != exp_byte[gi]);
    end
  endgenerate

  assign lcrc_bad = |byte_bad;

  always_comb begin
    sr_d        = sr_q;
    fill_d      = fill_q;
    crc_d       = crc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    err_d       = 1'b0;
    ok_d        = 1'b0;
    runt_d      = 1'b0;

    if (out_valid_q && m_axis_tready) out_valid_d = 1'b0;

    if (accept) begin
      if (!full) begin
        if (s_axis_tlast) begin
          // Packet too short to hold even one payload byte plus LCRC.
          fill_d = 3'd0;
          crc_d  = LCRC_SEED;
          runt_d = 1'b1;
        end else begin
          sr_d[0] = s_axis_tdata;
          sr_d[1] = sr_q[0];
          sr_d[2] = sr_q[1];
          sr_d[3] = sr_q[2];
          fill_d  = fill_q + 3'd1;
        end
      end else begin
        out_data_d  = sr_q[3];
        out_valid_d = 1'b1;
        if (s_axis_tlast) begin
          out_last_d = 1'b1;
          out_user_d = lcrc_bad;
          err_d      = lcrc_bad;
          ok_d       = !lcrc_bad;
          fill_d     = 3'd0;
          crc_d      = LCRC_SEED;
        end else begin
          out_last_d = 1'b0;
          out_user_d = 1'b0;
          crc_d      = crc_final;
          sr_d[0]    = s_axis_tdata;
          sr_d[1]    = sr_q[0];
          sr_d[2]    = sr_q[1];
          sr_d[3]    = sr_q[2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) sr_q[i] <= 8'h00;
      fill_q      <= 3'd0;
      crc_q       <= LCRC_SEED;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      err_q       <= 1'b0;
      ok_q        <= 1'b0;
      runt_q      <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) sr_q[i] <= sr_d[i];
      fill_q      <= fill_d;
      crc_q       <= crc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      err_q       <= err_d;
      ok_q        <= ok_d;
      runt_q      <= runt_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign crc_err       = err_q;
  assign crc_ok        = ok_q;
  assign runt_err      = runt_q;

endmodule

// File: tb/tb_pcie_lcrc_rx_check.sv
// Directed and randomised-traffic bench for pcie_lcrc_rx_check with a reference LCRC model.
module tb_pcie_lcrc_rx_check;

  typedef logic [7:0] byte_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast;
  logic       m_tuser;
  logic       crc_err;
  logic       crc_ok;
  logic       runt_err;

  pcie_lcrc_rx_check dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .crc_err(crc_err), .crc_ok(crc_ok), .runt_err(runt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: {tuser, tlast, data} per accepted beat, pulse log, stall stability.
  logic [9:0] out_q[$];
  int         pulse_q[$];
  int         ok_cnt, err_cnt, runt_cnt, stall_viol;
  int         first_in, first_out;
  bit         prev_stall;
  logic [9:0] prev_beat;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && first_out < 0) first_out = cyc;
      if (prev_stall && (!m_tvalid || {m_tuser, m_tlast, m_tdata} != prev_beat)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
      if (m_tvalid && m_tready) out_q.push_back({m_tuser, m_tlast, m_tdata});
      if (crc_ok)   begin ok_cnt++;   pulse_q.push_back(1); end
      if (crc_err)  begin err_cnt++;  pulse_q.push_back(2); end
      if (runt_err) begin runt_cnt++; pulse_q.push_back(3); end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    pulse_q.delete();
    ok_cnt = 0; err_cnt = 0; runt_cnt = 0; stall_viol = 0;
    first_in = -1; first_out = -1;
  endtask

  // Reference LCRC: CRC-32 0x04C11DB7, seed all-ones, byte bit 0 first.
  task automatic make_pkt(input byte_t pay[$], output byte_t pkt[$]);
    logic [31:0] r;
    logic [31:0] inv;
    byte_t       b;
    byte_t       rev;
    r = 32'hFFFF_FFFF;
    pkt = pay;
    foreach (pay[i]) begin
      b = pay[i];
      for (int j = 0; j < 8; j++) begin
        if (r[31] ^ b[j]) r = (r << 1) ^ 32'h04C1_1DB7;
        else              r = r << 1;
      end
    end
    inv = ~r;
    for (int k = 0; k < 4; k++) begin
      b = inv[31-8*k -: 8];
      for (int j = 0; j < 8; j++) rev[j] = b[7-j];
      pkt.push_back(rev);
    end
  endtask

  task automatic send_byte(input byte_t b, input bit last, input bit gaps);
    bit acc;
    int t;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    s_tdata = b; s_tlast = last; s_tvalid = 1'b1;
    acc = 1'b0; t = 0;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = s_tready;
      if (acc && first_in < 0) first_in = cyc;
      @(posedge clk); #1;
      t++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL handshake_timeout got=%0d expected=1", acc);
    end
  endtask

  task automatic send_pkt(input byte_t pkt[$], input bit gaps);
    foreach (pkt[i]) send_byte(pkt[i], i == pkt.size() - 1, gaps);
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 5000) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b expected=0", s_tready); end
    total++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== 11'd0) begin
      bad++; $display("FAIL reset_mout got=%h expected=000", {m_tvalid, m_tuser, m_tlast, m_tdata});
    end
    total++;
    if ({crc_err, crc_ok, runt_err} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b expected=000", {crc_err, crc_ok, runt_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    $display("test_reset done");
  endtask

  task automatic test_good();
    byte_t pay[$];
    byte_t pkt[$];
    for (int i = 0; i < 12; i++) pay.push_back(8'(i));
    make_pkt(pay, pkt);
    clear_mon();
    send_pkt(pkt, 1'b0);
    wait_beats(12);
    total++;
    if (out_q.size() !== 12) begin bad++; $display("FAIL good_count got=%0d expected=12", out_q.size()); end
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== {1'b0, (i == 11), 8'(i)}) begin
        bad++; $display("FAIL good_beat%0d got=%h expected=%h", i, out_q[i], {1'b0, (i == 11), 8'(i)});
      end
    end
    total++;
    if (ok_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL good_pulses got=ok%0d/err%0d expected=ok1/err0", ok_cnt, err_cnt); end
    total++;
    if (first_out - first_in !== 5) begin bad++; $display("FAIL good_latency got=%0d expected=5", first_out - first_in); end
    $display("test_good done: beats=%0d", out_q.size());
  endtask

  task automatic test_corrupt(input bit in_payload);
    byte_t pay[$];
    byte_t pkt[$];
    for (int i = 0; i < 12; i++) pay.push_back(8'(i));
    make_pkt(pay, pkt);
    if (in_payload) pkt[5] = pkt[5] ^ 8'h80;
    else            pkt[15] = pkt[15] ^ 8'h01;
    clear_mon();
    send_pkt(pkt, 1'b0);
    wait_beats(12);
    total++;
    if (out_q.size() !== 12) begin bad++; $display("FAIL corrupt_count got=%0d expected=12", out_q.size()); end
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== {(i == 11), (i == 11), pkt[i]}) begin
        bad++; $display("FAIL corrupt_beat%0d got=%h expected=%h", i, out_q[i], {(i == 11), (i == 11), pkt[i]});
      end
    end
    total++;
    if (ok_cnt !== 0 || err_cnt !== 1) begin bad++; $display("FAIL corrupt_pulses got=ok%0d/err%0d expected=ok0/err1", ok_cnt, err_cnt); end
    $display("test_corrupt(payload=%0d) done: beats=%0d", in_payload, out_q.size());
  endtask

  task automatic test_runts();
    byte_t pay[$];
    byte_t pkt[$];
    byte_t r4[$];
    for (int n = 1; n <= 4; n += 3) begin
      r4.delete();
      for (int i = 0; i < n; i++) r4.push_back(8'(8'h40 + i));
      clear_mon();
      send_pkt(r4, 1'b0);
      wait_beats(0);
      total++;
      if (out_q.size() !== 0 || runt_cnt !== 1) begin
        bad++; $display("FAIL runt%0d got=beats%0d/runt%0d expected=beats0/runt1", n, out_q.size(), runt_cnt);
      end
      $display("test_runts len=%0d done", n);
    end
    pay.push_back(8'hA5);
    make_pkt(pay, pkt);
    clear_mon();
    send_pkt(pkt, 1'b0);
    wait_beats(1);
    total++;
    if (out_q.size() !== 1 || out_q[0] !== 10'h1A5) begin
      bad++; $display("FAIL runt5_beat got=n%0d/%h expected=n1/1a5", out_q.size(), out_q.size() ? out_q[0] : 10'h0);
    end
    total++;
    if (ok_cnt !== 1 || runt_cnt !== 0) begin bad++; $display("FAIL runt5_pulses got=ok%0d/runt%0d expected=ok1/runt0", ok_cnt, runt_cnt); end
    $display("test_runts len=5 done");
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_q[$];
    byte_t      pay[$];
    byte_t      pkt[$];
    int         exp_ok, exp_err, len, mism;
    bit         corrupt;
    exp_ok = 0; exp_err = 0;
    clear_mon();
    rand_rdy = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(5, 64);
      pay.delete();
      for (int i = 0; i < len - 4; i++) pay.push_back(8'($urandom_range(0, 255)));
      make_pkt(pay, pkt);
      corrupt = (p % 4 == 3);
      if (corrupt) begin
        int k;
        k = len - 4 + $urandom_range(0, 3);
        pkt[k] = pkt[k] ^ (8'h01 << $urandom_range(0, 7));
        exp_err++;
      end else begin
        exp_ok++;
      end
      foreach (pay[i]) exp_q.push_back({corrupt && (i == len - 5), (i == len - 5), pay[i]});
      send_pkt(pkt, 1'b1);
    end
    wait_beats(exp_q.size());
    rand_rdy = 1'b0;
    total++;
    if (out_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d expected=%0d", out_q.size(), exp_q.size()); end
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) mism++;
    total++;
    if (mism !== 0) begin bad++; $display("FAIL bp_stream got=%0d_mismatched_beats expected=0", mism); end
    total++;
    if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin
      bad++; $display("FAIL bp_pulses got=ok%0d/err%0d expected=ok%0d/err%0d", ok_cnt, err_cnt, exp_ok, exp_err);
    end
    total++;
    if (stall_viol !== 0) begin bad++; $display("FAIL bp_stall_stable got=%0d expected=0", stall_viol); end
    $display("test_backpressure done: beats=%0d ok=%0d err=%0d", out_q.size(), ok_cnt, err_cnt);
  endtask

  task automatic test_back_to_back();
    byte_t      pay[$];
    byte_t      pkt[$];
    byte_t      all[$];
    logic [2:0] users;
    int         li;
    for (int p = 0; p < 3; p++) begin
      pay.delete();
      for (int i = 0; i < 8; i++) pay.push_back(8'(16 * p + i));
      make_pkt(pay, pkt);
      if (p == 1) pkt[2] = pkt[2] ^ 8'h10;
      foreach (pkt[i]) all.push_back(pkt[i]);
    end
    clear_mon();
    foreach (all[i]) send_byte(all[i], (i % 12) == 11, 1'b0);
    wait_beats(24);
    total++;
    if (out_q.size() !== 24) begin bad++; $display("FAIL b2b_count got=%0d expected=24", out_q.size()); end
    users = 3'b000; li = 0;
    foreach (out_q[i]) if (out_q[i][8] && li < 3) begin users[li] = out_q[i][9]; li++; end
    total++;
    if (users !== 3'b010 || li !== 3) begin bad++; $display("FAIL b2b_tuser got=%b/%0d expected=010/3", users, li); end
    total++;
    if (pulse_q.size() !== 3 || pulse_q[0] !== 1 || pulse_q[1] !== 2 || pulse_q[2] !== 1) begin
      bad++; $display("FAIL b2b_pulses got=n%0d expected=ok,err,ok", pulse_q.size());
    end
    $display("test_back_to_back done: beats=%0d", out_q.size());
  endtask

  task automatic test_reset_mid();
    byte_t pay[$];
    byte_t pkt[$];
    for (int i = 0; i < 16; i++) pay.push_back(8'(8'h80 + i));
    make_pkt(pay, pkt);
    for (int i = 0; i < 7; i++) send_byte(pkt[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({s_tready, m_tvalid} !== 2'b00) begin bad++; $display("FAIL midrst_outputs got=%b expected=00", {s_tready, m_tvalid}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back(8'(8'hC0 + i));
    make_pkt(pay, pkt);
    send_pkt(pkt, 1'b0);
    wait_beats(6);
    total++;
    if (out_q.size() !== 6) begin bad++; $display("FAIL midrst_count got=%0d expected=6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== {1'b0, (i == 5), 8'(8'hC0 + i)}) begin
        bad++; $display("FAIL midrst_beat%0d got=%h expected=%h", i, out_q[i], {1'b0, (i == 5), 8'(8'hC0 + i)});
      end
    end
    total++;
    if (ok_cnt !== 1 || err_cnt !== 0 || runt_cnt !== 0) begin
      bad++; $display("FAIL midrst_pulses got=ok%0d/err%0d/runt%0d expected=1/0/0", ok_cnt, err_cnt, runt_cnt);
    end
    $display("test_reset_mid done: beats=%0d", out_q.size());
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_good();
    test_corrupt(1'b0);
    test_corrupt(1'b1);
    test_runts();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
